// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
// Holds the sequencer state enum, instruction width and a range helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    LOAD,
    FLUSH,
    RUN,
    HALT
  } state_t;

  localparam int unsigned INSTR_BYTES = 4;

  // True when a whole instruction word starting at adr lies below size.
  function automatic logic word_fits(
    input logic [63:0] adr,
    input logic [63:0] size
  );
    return (adr + 64'(INSTR_BYTES - 1)) < size;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of loader, redirect, imem and fetch-output signals.
// master: sequencer side, slave: loader/decode/memory side.
interface fetch_sequencer_if;

  logic        load_valid;
  logic        load_ready;
  logic [63:0] load_addr;
  logic [7:0]  load_byte;
  logic        load_done;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic [63:0] imem_adr;
  logic        imem_we;
  logic [7:0]  imem_wdata;
  logic [31:0] imem_rdata;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        halted;
  logic        load_err;

  modport master (
    input  load_valid, load_addr, load_byte,
    input  load_done, stall,
    input  branch_taken, branch_target,
    input  imem_rdata,
    output load_ready,
    output imem_adr, imem_we, imem_wdata,
    output if_pc, if_instr, if_valid,
    output halted, load_err
  );

  modport slave (
    output load_valid, load_addr, load_byte,
    output load_done, stall,
    output branch_taken, branch_target,
    output imem_rdata,
    input  load_ready,
    input  imem_adr, imem_we, imem_wdata,
    input  if_pc, if_instr, if_valid,
    input  halted, load_err
  );

endinterface

// File: rtl/fetch_sequencer.sv
// Loads an instruction image byte by byte, then fetches words in order.
// Ports: loader (load_*), redirect (stall/branch_*), imem bus, IF outputs.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned MEM_SIZE = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [63:0] load_addr,
  input  logic [7:0]  load_byte,
  input  logic        load_done,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic [63:0] imem_adr,
  output logic        imem_we,
  output logic [7:0]  imem_wdata,
  input  logic [31:0] imem_rdata,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid,
  output logic        halted,
  output logic        load_err
);

  localparam logic [63:0] MEM_LIMIT = 64'(MEM_SIZE);

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        if_valid_q, if_valid_d;
  logic        load_err_q, load_err_d;

  logic        load_hit;
  logic        load_miss;
  logic        tgt_bad;

  assign load_hit  = load_valid && (load_addr < MEM_LIMIT);
  assign load_miss = load_valid && !(load_addr < MEM_LIMIT);
  assign tgt_bad   = (branch_target[1:0] != 2'b00)
                  || !word_fits(branch_target, MEM_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= LOAD;
      pc_q       <= RESET_PC;
      if_pc_q    <= '0;
      if_instr_q <= '0;
      if_valid_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
      load_err_q <= load_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    load_err_d = load_err_q;
    unique case (state_q)
      LOAD: begin
        if (load_miss) load_err_d = 1'b1;
        if (load_done) state_d = FLUSH;
      end
      FLUSH: begin
        pc_d       = RESET_PC;
        if_valid_d = 1'b0;
        state_d    = RUN;
      end
      RUN: begin
        // Redirect wins over stall and always leaves one bubble.
        if (branch_taken) begin
          if_valid_d = 1'b0;
          if (tgt_bad) state_d = HALT;
          else         pc_d    = branch_target;
        end else if (!stall) begin
          if (!word_fits(pc_q, MEM_LIMIT)) begin
            if_valid_d = 1'b0;
            state_d    = HALT;
          end else begin
            if_instr_d = imem_rdata;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            pc_d       = pc_q + 64'(INSTR_BYTES);
          end
        end
      end
      HALT: begin
        if_valid_d = 1'b0;
      end
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    load_ready = 1'b0;
    imem_we    = 1'b0;
    imem_adr   = pc_q;
    imem_wdata = 8'h00;
    halted     = (state_q == HALT);
    if (state_q == LOAD) begin
      load_ready = 1'b1;
      imem_adr   = load_addr;
      imem_wdata = load_byte;
      // Keep the memory untouched while reset is held.
      imem_we    = load_hit && !reset;
    end
  end

  assign if_pc    = if_pc_q;
  assign if_instr = if_instr_q;
  assign if_valid = if_valid_q;
  assign load_err = load_err_q;

endmodule
